// File: rtl/otter_mem_arbiter.sv
// Round-robin arbiter sharing the single-port OTTER BRAM between instruction fetch and load/store.
// Each access runs IDLE -> ISSUE -> RESP; store data is lane-replicated and load data is extended.
module otter_mem_arbiter #(
  parameter int unsigned BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  // Instruction fetch requester
  input  logic                 if_req,
  input  logic [BUS_WIDTH-1:0] if_addr,
  output logic                 if_ready,
  output logic                 if_rvalid,
  output logic [BUS_WIDTH-1:0] if_rdata,
  output logic                 if_err,
  // Load/store requester
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [BUS_WIDTH-1:0] d_addr,
  input  logic [BUS_WIDTH-1:0] d_wdata,
  input  logic [1:0]           d_size,
  input  logic                 d_sign,
  output logic                 d_ready,
  output logic                 d_rvalid,
  output logic [BUS_WIDTH-1:0] d_rdata,
  output logic                 d_err,
  // Memory port
  output logic                 mem_we,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_data,
  output logic [1:0]           mem_size,
  output logic                 mem_sign,
  input  logic [BUS_WIDTH-1:0] mem_out,
  input  logic                 mem_error
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e               state_q, state_d;
  logic                 last_if_q, last_if_d;  // 1: IF won the previous accept
  logic                 own_if_q, own_if_d;
  logic [BUS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic                 sign_q, sign_d;
  logic [1:0]           size_q, size_d;
  logic                 err_q, err_d;

  logic                 grant_if;
  logic [BUS_WIDTH-1:0] d_wdata_rep;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [BUS_WIDTH-1:0] ld_fmt;

  always_comb begin
    d_wdata_rep = d_wdata;
    unique case (d_size)
      2'b00:   d_wdata_rep = {4{d_wdata[7:0]}};
      2'b01:   d_wdata_rep = {2{d_wdata[15:0]}};
      default: d_wdata_rep = d_wdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    last_if_d = last_if_q;
    own_if_d  = own_if_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    sign_d    = sign_q;
    size_d    = size_q;
    err_d     = err_q;
    if_ready  = 1'b0;
    d_ready   = 1'b0;

    // On a tie the requester that did not win last time gets the grant.
    grant_if = if_req & (~d_req | ~last_if_q);

    unique case (state_q)
      StIdle: begin
        if_ready = grant_if;
        d_ready  = d_req & ~grant_if;
        if (grant_if) begin
          addr_d    = if_addr;
          wdata_d   = '0;
          we_d      = 1'b0;
          sign_d    = 1'b0;
          size_d    = 2'b10;
          own_if_d  = 1'b1;
          last_if_d = 1'b1;
          state_d   = StIssue;
        end else if (d_req) begin
          addr_d    = d_addr;
          wdata_d   = d_wdata_rep;
          we_d      = d_we;
          sign_d    = d_sign;
          size_d    = d_size;
          own_if_d  = 1'b0;
          last_if_d = 1'b0;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        err_d   = mem_error;
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_if_q <= 1'b0;
      own_if_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      sign_q    <= 1'b0;
      size_q    <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_if_q <= last_if_d;
      own_if_q  <= own_if_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      sign_q    <= sign_d;
      size_q    <= size_d;
      err_q     <= err_d;
    end
  end

  // Memory port is driven from the latches at all times so the BRAM address never glitches.
  always_comb begin
    mem_addr = addr_q;
    mem_data = wdata_q;
    mem_size = size_q;
    mem_sign = sign_q;
    mem_we   = (state_q == StIssue) & we_q & ~mem_error;
  end

  always_comb begin
    ld_byte = mem_out[7:0];
    unique case (addr_q[1:0])
      2'b00:   ld_byte = mem_out[7:0];
      2'b01:   ld_byte = mem_out[15:8];
      2'b10:   ld_byte = mem_out[23:16];
      default: ld_byte = mem_out[31:24];
    endcase
    ld_half = addr_q[1] ? mem_out[31:16] : mem_out[15:0];

    ld_fmt = mem_out;
    unique case (size_q)
      2'b00:   ld_fmt = {{(BUS_WIDTH - 8){sign_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_fmt = {{(BUS_WIDTH - 16){sign_q & ld_half[15]}}, ld_half};
      default: ld_fmt = mem_out;
    endcase
  end

  always_comb begin
    if_rvalid = (state_q == StResp) & own_if_q;
    d_rvalid  = (state_q == StResp) & ~own_if_q;
    if_err    = if_rvalid & err_q;
    d_err     = d_rvalid & err_q;
    if_rdata  = (if_rvalid & ~err_q) ? mem_out : '0;
    d_rdata   = (d_rvalid & ~err_q & ~we_q) ? ld_fmt : '0;
  end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Bench for otter_mem_arbiter: BRAM model, directed vector table, randomized traffic against a
// byte-level reference memory, and hand-written arbitration and reset sequences.
module tb_otter_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_size = 2'b10;
  logic        d_sign = 1'b0;
  logic        d_ready, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_we, mem_sign, mem_error;
  logic [31:0] mem_addr, mem_data, mem_out;
  logic [1:0]  mem_size;

  logic        preload = 1'b1;
  logic [31:0] mem [0:2047];
  logic [7:0]  ref_mem [0:8191];

  int n_asserts = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  otter_mem_arbiter #(.BUS_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_sign(d_sign), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_size(mem_size),
    .mem_sign(mem_sign), .mem_out(mem_out), .mem_error(mem_error)
  );

  // 8 KiB BRAM, synchronous read, lane write enables derived from address and size.
  assign mem_error = (mem_size == 2'b11) || (mem_size == 2'b01 && mem_addr[0]) ||
                     (mem_size == 2'b10 && mem_addr[1:0] != 2'b00) || (mem_addr >= 32'h2000);

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) mem[i] <= '0;
      mem[4] <= 32'hDEADBEEF;
    end else if (mem_we) begin
      case (mem_size)
        2'b00:   mem[mem_addr[12:2]][{mem_addr[1:0], 3'b000} +: 8] <=
                     mem_data[{mem_addr[1:0], 3'b000} +: 8];
        2'b01:   mem[mem_addr[12:2]][{mem_addr[1], 4'b0000} +: 16] <=
                     mem_data[{mem_addr[1], 4'b0000} +: 16];
        default: mem[mem_addr[12:2]] <= mem_data;
      endcase
    end
    mem_out <= mem[mem_addr[12:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: little-endian byte memory; sizes 1/2/4 bytes, natural alignment, 8 KiB range.
  task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic sign,
                            output logic [31:0] rdata, output logic err);
    int n;
    longint v;
    n = 1 << size;
    err = (addr % n != 0) || (addr >= 32'h2000);
    rdata = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
      if (sign && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      rdata = 32'(v);
    end
  endtask

  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sign,
                          output logic [31:0] rdata, output logic err, output logic mwe,
                          output logic [31:0] mdata, output logic ok);
    int waitc = 0;
    ok = 1'b0;
    rdata = '0; err = 1'b0; mwe = 1'b0; mdata = '0;
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_size = size; d_sign = sign;
    #1;
    while (!d_ready && waitc < 20) begin
      @(negedge clk); #1;
      waitc++;
    end
    if (!d_ready) begin
      chk("d_ready_timeout", d_ready, 1);
      d_req = 1'b0;
      return;
    end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    mwe = mem_we;
    mdata = mem_data;
    chk("d_rvalid_in_issue", d_rvalid, 0);
    @(negedge clk); #1;
    chk("d_rvalid_in_resp", d_rvalid, 1);
    chk("if_rvalid_during_d", if_rvalid, 0);
    rdata = d_rdata;
    err = d_err;
    ok = 1'b1;
  endtask

  task automatic if_fetch(input logic [31:0] addr, output logic [31:0] rdata, output logic err,
                          output logic ok);
    int waitc = 0;
    ok = 1'b0; rdata = '0; err = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    #1;
    while (!if_ready && waitc < 20) begin
      @(negedge clk); #1;
      waitc++;
    end
    if (!if_ready) begin
      chk("if_ready_timeout", if_ready, 1);
      if_req = 1'b0;
      return;
    end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("if_mem_we_issue", mem_we, 0);
    @(negedge clk); #1;
    chk("if_rvalid_in_resp", if_rvalid, 1);
    chk("d_rvalid_during_if", d_rvalid, 0);
    rdata = if_rdata;
    err = if_err;
    ok = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_mwe;
    logic [31:0] exp_mdata;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic [31:0] r, er, mdata;
    logic        e, ee, mwe, ok;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        we, sg;

    vecs[0]  = '{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h13,   32'h123456A5, 2'b00, 1'b0, 32'h0,        1'b0, 1'b1, 32'hA5A5A5A5};
    vecs[2]  = '{1'b0, 32'h13,   32'h0,        2'b00, 1'b1, 32'hFFFFFFA5, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h13,   32'h0,        2'b00, 1'b0, 32'h000000A5, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'hA5ADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h16,   32'hBEEF8001, 2'b01, 1'b0, 32'h0,        1'b0, 1'b1, 32'h80018001};
    vecs[6]  = '{1'b0, 32'h16,   32'h0,        2'b01, 1'b1, 32'hFFFF8001, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h16,   32'h0,        2'b01, 1'b0, 32'h00008001, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h10,   32'h0,        2'b01, 1'b1, 32'hFFFFBEEF, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h11,   32'h0,        2'b00, 1'b0, 32'h000000BE, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h12,   32'h12345678, 2'b10, 1'b0, 32'h0,        1'b1, 1'b0, 32'h12345678};
    vecs[11] = '{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'hA5ADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'h14,   32'h0,        2'b10, 1'b0, 32'h80010000, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h4000, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 32'h4000, 32'h000000A5, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 32'hA5A5A5A5};
    vecs[15] = '{1'b0, 32'h10,   32'h0,        2'b00, 1'b1, 32'hFFFFFFEF, 1'b0, 1'b0, 32'h0};
    vecs[16] = '{1'b1, 32'h18,   32'h89ABCDEF, 2'b10, 1'b0, 32'h0,        1'b0, 1'b1, 32'h89ABCDEF};
    vecs[17] = '{1'b0, 32'h1A,   32'h0,        2'b01, 1'b1, 32'hFFFF89AB, 1'b0, 1'b0, 32'h0};

    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
    ref_mem[16] = 8'hEF; ref_mem[17] = 8'hBE; ref_mem[18] = 8'hAD; ref_mem[19] = 8'hDE;

    // Reset state, with both requesters already asking for a word at 0x10.
    repeat (2) @(posedge clk);
    preload = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_size = 2'b10; d_sign = 1'b0;
    @(negedge clk); #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_mem_size", mem_size, 0);
    chk("rst_mem_sign", mem_sign, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_errs", {if_err, d_err}, 0);

    // Held tie: IF, D, IF, D with an accept every third cycle.
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("tie_if_ready_%0d", k), if_ready, (k % 6) == 0);
      chk($sformatf("tie_d_ready_%0d", k), d_ready, (k % 6) == 3);
      chk($sformatf("tie_if_rvalid_%0d", k), if_rvalid, (k % 6) == 2);
      chk($sformatf("tie_d_rvalid_%0d", k), d_rvalid, (k % 6) == 5);
      if ((k % 6) == 2) chk("tie_if_rdata", if_rdata, 32'hDEADBEEF);
      if ((k % 6) == 5) chk("tie_d_rdata", d_rdata, 32'hDEADBEEF);
      @(negedge clk); #1;
    end
    // Dropping requests before the accept edge must not start an access.
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("drop_no_rvalid", {if_rvalid, d_rvalid}, 0);
    end

    foreach (vecs[i]) begin
      d_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].sign,
               r, e, mwe, mdata, ok);
      if (ok) begin
        ref_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].sign, er, ee);
        chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
        chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
        if (vecs[i].we) begin
          chk($sformatf("vec%0d_mem_we", i), mwe, vecs[i].exp_mwe);
          chk($sformatf("vec%0d_mem_data", i), mdata, vecs[i].exp_mdata);
        end else begin
          chk($sformatf("vec%0d_load_mem_we", i), mwe, 0);
        end
      end
    end

    // Randomized traffic against the byte-level reference.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = 32'($urandom_range(0, 31)) << 2;
        if_fetch(a, r, e, ok);
        if (ok) begin
          ref_access(1'b0, a, 32'h0, 2'b10, 1'b0, er, ee);
          chk($sformatf("rnd%0d_if_rdata", i), r, er);
          chk($sformatf("rnd%0d_if_err", i), e, ee);
        end
      end else begin
        we = 1'($urandom_range(0, 1));
        sg = 1'($urandom_range(0, 1));
        sz = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0) a = 32'h2000 + 32'($urandom_range(0, 255));
        else a = 32'($urandom_range(0, 127));
        d_access(we, a, $urandom, sz, sg, r, e, mwe, mdata, ok);
        if (ok) begin
          ref_access(we, a, d_wdata, sz, sg, er, ee);
          chk($sformatf("rnd%0d_d_rdata", i), r, er);
          chk($sformatf("rnd%0d_d_err", i), e, ee);
          chk($sformatf("rnd%0d_mem_we", i), mwe, we & ~ee);
        end
      end
    end

    // Asynchronous reset in the ISSUE cycle of a store.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFEF00D; d_size = 2'b10;
    #1;
    chk("mid_d_ready", d_ready, 1);
    @(posedge clk);
    #2;
    d_req = 1'b0;
    chk("mid_mem_we_issue", mem_we, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_mem_we_async_drop", mem_we, 0);
    chk("mid_mem_addr_rst", mem_addr, 0);
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_tie_if_ready", if_ready, 1);
    chk("post_rst_tie_d_ready", d_ready, 0);
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("post_rst_no_rvalid", {if_rvalid, d_rvalid}, 0);
    end
    d_access(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, r, e, mwe, mdata, ok);
    if (ok) begin
      ref_access(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, er, ee);
      chk("aborted_store_not_written", r, er);
      chk("aborted_store_err", e, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
